mti_integrator: RTL and testbench

- Parametrised moving-target-indication and pulse-integration stage, placed after pulse compression in the receiver chain.
- Takes complex pulse-compressed range samples pulse by pulse.
- Applies a selectable 2-pulse or 3-pulse clutter canceller per range cell, or bypasses it.
- Non-coherently accumulates |y|^2 per range cell over a CPI of PRF_N pulses.

---
 rtl/mti_integrator.sv | 200 ++++++++++++++++++++
 tb/tb_mti_integrator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mti_integrator.sv
// MTI clutter canceller (bypass / 2-pulse / 3-pulse) per range cell, followed by
// non-coherent |y|^2 integration per range cell over a CPI of PRF_N pulses.
module mti_integrator #(
    parameter int WIDTH   = 12,
    parameter int RANGE_N = 256,
    parameter int PRF_N   = 16,
    parameter int RW      = $clog2(RANGE_N),
    parameter int PW      = $clog2(PRF_N),
    parameter int OW      = WIDTH + 2,
    parameter int AW      = 2*OW + 1 + $clog2(PRF_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             pulse_start,
    input  logic [WIDTH-1:0] in_I,
    input  logic [WIDTH-1:0] in_Q,
    input  logic [1:0]       mode,
    output logic             mti_valid,
    output logic [OW-1:0]    mti_I,
    output logic [OW-1:0]    mti_Q,
    output logic [RW-1:0]    range_idx,
    output logic [PW-1:0]    pulse_idx,
    output logic             acc_valid,
    output logic [AW-1:0]    acc_out,
    output logic             overrun
);
    localparam int PWID = 2*OW + 1;
    localparam int XW   = 2*WIDTH;
    localparam logic [RW-1:0] RLAST = RW'(RANGE_N - 1);
    localparam logic [PW-1:0] PLAST = PW'(PRF_N - 1);

    function automatic logic [OW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(OW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [OW-1:0] cancel(input logic [1:0] m, input logic primed,
                                             input logic [WIDTH-1:0] a0, a1, a2);
        logic [OW-1:0] y;
        case (m)
            2'd1:    y = sext(a0) - sext(a1);
            2'd2:    y = sext(a0) - (sext(a1) << 1) + sext(a2);
            default: y = sext(a0);
        endcase
        return primed ? y : '0;
    endfunction

    logic          accept, primed_d;
    logic [1:0]    mode_norm, prime_q, prime_d, mode_q, mode_d;
    logic [RW-1:0] range_q, range_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic          started_q, started_d, overrun_q, overrun_d;

    // Input counters, CPI mode latch and priming state.
    always_comb begin
        accept    = in_valid && (pulse_start || range_q != RLAST);
        mode_norm = (mode == 2'd3) ? 2'd0 : mode;
        range_d   = range_q;
        pulse_d   = pulse_q;
        prime_d   = prime_q;
        mode_d    = mode_q;
        started_d = started_q;
        overrun_d = overrun_q || (in_valid && !accept);
        if (accept) begin
            if (pulse_start) begin
                range_d   = '0;
                started_d = 1'b1;
                if (started_q) begin
                    pulse_d = (pulse_q == PLAST) ? '0 : pulse_q + PW'(1);
                    if (prime_q != 2'd2) prime_d = prime_q + 2'd1;
                end
                if (pulse_d == '0) begin
                    mode_d = mode_norm;
                    if (mode_norm != mode_q) prime_d = 2'd0;
                end
            end else begin
                range_d = range_q + RW'(1);
            end
        end
        case (mode_d)
            2'd1:    primed_d = (prime_d != 2'd0);
            2'd2:    primed_d = (prime_d == 2'd2);
            default: primed_d = 1'b1;
        endcase
    end

    logic [XW-1:0] dl1_ram [RANGE_N];
    logic [XW-1:0] dl2_ram [RANGE_N];
    logic [AW-1:0] acc_ram [RANGE_N];
    logic [XW-1:0] x0_q, x1_q, x2_q, x1_d, x2_d;
    logic          s1_valid_q, s1_primed_q;
    logic [1:0]    s1_mode_q;
    logic [RW-1:0] s1_range_q;
    logic [PW-1:0] s1_pulse_q;

    logic          mti_valid_q;
    logic [OW-1:0] mti_i_q, mti_q_q, mti_i_d, mti_q_d;
    logic [RW-1:0] range_idx_q;
    logic [PW-1:0] pulse_idx_q;

    logic            s3_valid_q;
    logic [RW-1:0]   s3_range_q;
    logic [PW-1:0]   s3_pulse_q;
    logic [PWID-1:0] p_q, p_d, ext_i, ext_q;
    logic [AW-1:0]   acc_rd_q, acc_rd_d, sum_d, acc_out_q, acc_out_d;
    logic            acc_valid_q, acc_valid_d;

    always_comb begin
        x1_d     = dl1_ram[range_d];
        x2_d     = dl2_ram[range_d];
        mti_i_d  = cancel(s1_mode_q, s1_primed_q, x0_q[XW-1:WIDTH], x1_q[XW-1:WIDTH], x2_q[XW-1:WIDTH]);
        mti_q_d  = cancel(s1_mode_q, s1_primed_q, x0_q[WIDTH-1:0], x1_q[WIDTH-1:0], x2_q[WIDTH-1:0]);
        ext_i    = {{(PWID-OW){mti_i_q[OW-1]}}, mti_i_q};
        ext_q    = {{(PWID-OW){mti_q_q[OW-1]}}, mti_q_q};
        p_d      = ext_i * ext_i + ext_q * ext_q;
        acc_rd_d = acc_ram[range_idx_q];
        // Pulse 0 of a CPI starts a fresh sum, so stale RAM contents never leak in.
        sum_d       = ((s3_pulse_q == '0) ? '0 : acc_rd_q) + {{(AW-PWID){1'b0}}, p_q};
        acc_valid_d = s3_valid_q && (s3_pulse_q == PLAST);
        acc_out_d   = acc_valid_d ? sum_d : acc_out_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dl1_ram[range_d] <= {in_I, in_Q};
            dl2_ram[range_d] <= dl1_ram[range_d];
        end
        x1_q     <= x1_d;
        x2_q     <= x2_d;
        acc_rd_q <= acc_rd_d;
        if (s3_valid_q) acc_ram[s3_range_q] <= sum_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            range_q     <= '0;
            pulse_q     <= '0;
            prime_q     <= '0;
            mode_q      <= '0;
            started_q   <= 1'b0;
            overrun_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_primed_q <= 1'b0;
            s1_mode_q   <= '0;
            s1_range_q  <= '0;
            s1_pulse_q  <= '0;
            x0_q        <= '0;
            mti_valid_q <= 1'b0;
            mti_i_q     <= '0;
            mti_q_q     <= '0;
            range_idx_q <= '0;
            pulse_idx_q <= '0;
            s3_valid_q  <= 1'b0;
            s3_range_q  <= '0;
            s3_pulse_q  <= '0;
            p_q         <= '0;
            acc_valid_q <= 1'b0;
            acc_out_q   <= '0;
        end else begin
            range_q     <= range_d;
            pulse_q     <= pulse_d;
            prime_q     <= prime_d;
            mode_q      <= mode_d;
            started_q   <= started_d;
            overrun_q   <= overrun_d;
            s1_valid_q  <= accept;
            if (accept) begin
                s1_primed_q <= primed_d;
                s1_mode_q   <= mode_d;
                s1_range_q  <= range_d;
                s1_pulse_q  <= pulse_d;
                x0_q        <= {in_I, in_Q};
            end
            mti_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                mti_i_q     <= mti_i_d;
                mti_q_q     <= mti_q_d;
                range_idx_q <= s1_range_q;
                pulse_idx_q <= s1_pulse_q;
            end
            s3_valid_q  <= mti_valid_q;
            if (mti_valid_q) begin
                s3_range_q <= range_idx_q;
                s3_pulse_q <= pulse_idx_q;
                p_q        <= p_d;
            end
            acc_valid_q <= acc_valid_d;
            acc_out_q   <= acc_out_d;
        end
    end

    assign mti_valid = mti_valid_q;
    assign mti_I     = mti_i_q;
    assign mti_Q     = mti_q_q;
    assign range_idx = range_idx_q;
    assign pulse_idx = pulse_idx_q;
    assign acc_valid = acc_valid_q;
    assign acc_out   = acc_out_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_mti_integrator.sv
// Bench for mti_integrator: directed CPIs plus random data, checked against a
// per-cell pulse-history reference model with cycle-exact latency expectations.
module tb_mti_integrator;
    localparam int WIDTH   = 12;
    localparam int RANGE_N = 8;
    localparam int PRF_N   = 16;
    localparam int RW      = $clog2(RANGE_N);
    localparam int PW      = $clog2(PRF_N);
    localparam int OW      = WIDTH + 2;
    localparam int AW      = 2*OW + 1 + $clog2(PRF_N);

    logic             clk, rst, in_valid, pulse_start;
    logic [WIDTH-1:0] in_I, in_Q;
    logic [1:0]       mode;
    logic             mti_valid, acc_valid, overrun;
    logic [OW-1:0]    mti_I, mti_Q;
    logic [RW-1:0]    range_idx;
    logic [PW-1:0]    pulse_idx;
    logic [AW-1:0]    acc_out;

    mti_integrator #(.WIDTH(WIDTH), .RANGE_N(RANGE_N), .PRF_N(PRF_N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pulse_start(pulse_start),
        .in_I(in_I), .in_Q(in_Q), .mode(mode),
        .mti_valid(mti_valid), .mti_I(mti_I), .mti_Q(mti_Q),
        .range_idx(range_idx), .pulse_idx(pulse_idx),
        .acc_valid(acc_valid), .acc_out(acc_out), .overrun(overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct { int cyc; int r; int p; int yi; int yq; } mti_t;
    typedef struct { int cyc; longint val; } acc_t;
    mti_t   mti_exp[$];
    acc_t   acc_exp[$];
    longint acc_last;
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
    endtask

    // ---------------- reference model ----------------
    // History per cell survives reset, as the delay-line RAMs do.
    bit     m_started, m_ovr;
    int     m_range, m_pulse, m_prime, m_mode, m_ovr_cyc;
    int     h1i[RANGE_N], h1q[RANGE_N], h2i[RANGE_N], h2q[RANGE_N];
    longint acc_m[RANGE_N];

    task automatic model_reset();
        m_started = 0; m_ovr = 0; m_ovr_cyc = 0;
        m_range = 0; m_pulse = 0; m_prime = 0; m_mode = 0;
        mti_exp.delete();
        acc_exp.delete();
        acc_last = 0;
    endtask

    task automatic model_step(input bit ps, input int xi, input int xq, input int md, input int c);
        int yi, yq, r, nm;
        longint pw;
        if (ps) begin
            if (m_started) begin
                m_pulse = (m_pulse + 1) % PRF_N;
                if (m_prime < 2) m_prime++;
            end
            m_started = 1;
            m_range   = 0;
            if (m_pulse == 0) begin
                nm = (md == 3) ? 0 : md;
                if (nm != m_mode) m_prime = 0;
                m_mode = nm;
            end
        end else if (m_range == RANGE_N - 1) begin
            if (!m_ovr) begin m_ovr = 1; m_ovr_cyc = c + 1; end
            return;
        end else begin
            m_range++;
        end
        r = m_range;
        if (m_mode == 1) begin
            yi = (m_prime >= 1) ? xi - h1i[r] : 0;
            yq = (m_prime >= 1) ? xq - h1q[r] : 0;
        end else if (m_mode == 2) begin
            yi = (m_prime >= 2) ? xi - 2*h1i[r] + h2i[r] : 0;
            yq = (m_prime >= 2) ? xq - 2*h1q[r] + h2q[r] : 0;
        end else begin
            yi = xi; yq = xq;
        end
        h2i[r] = h1i[r]; h2q[r] = h1q[r];
        h1i[r] = xi;     h1q[r] = xq;
        pw = longint'(yi) * yi + longint'(yq) * yq;
        acc_m[r] = (m_pulse == 0) ? pw : acc_m[r] + pw;
        mti_exp.push_back('{c + 2, r, m_pulse, yi, yq});
        if (m_pulse == PRF_N - 1) acc_exp.push_back('{c + 4, acc_m[r]});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        bit ev, ea;
        if (rst) begin
            while (mti_exp.size() > 0 && mti_exp[0].cyc < cyc) void'(mti_exp.pop_front());
            while (acc_exp.size() > 0 && acc_exp[0].cyc < cyc) void'(acc_exp.pop_front());
            ev = (mti_exp.size() > 0) && (mti_exp[0].cyc == cyc);
            check("mti_valid", 64'(mti_valid), 64'(ev));
            if (ev) begin
                check("mti_I", 64'($signed(mti_I)), 64'(mti_exp[0].yi));
                check("mti_Q", 64'($signed(mti_Q)), 64'(mti_exp[0].yq));
                check("range_idx", 64'(range_idx), 64'(mti_exp[0].r));
                check("pulse_idx", 64'(pulse_idx), 64'(mti_exp[0].p));
                void'(mti_exp.pop_front());
            end
            ea = (acc_exp.size() > 0) && (acc_exp[0].cyc == cyc);
            check("acc_valid", 64'(acc_valid), 64'(ea));
            if (ea) begin
                acc_last = acc_exp[0].val;
                void'(acc_exp.pop_front());
            end
            check("acc_out", 64'(acc_out), 64'(acc_last));
            check("overrun", 64'(overrun), 64'(m_ovr && cyc >= m_ovr_cyc));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0; pulse_start = 1'b0;
        end
    endtask

    task automatic drive(input bit ps, input int xi, input int xq, input int md);
        @(posedge clk); #1;
        in_valid = 1'b1; pulse_start = ps;
        in_I = WIDTH'(xi); in_Q = WIDTH'(xq); mode = 2'(md);
        model_step(ps, xi, xq, md, cyc);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0; in_valid = 1'b0; pulse_start = 1'b0;
        #1;
        check("rst mti_valid", 64'(mti_valid), 64'(0));
        check("rst mti_I", 64'(mti_I), 64'(0));
        check("rst mti_Q", 64'(mti_Q), 64'(0));
        check("rst range_idx", 64'(range_idx), 64'(0));
        check("rst pulse_idx", 64'(pulse_idx), 64'(0));
        check("rst acc_valid", 64'(acc_valid), 64'(0));
        check("rst acc_out", 64'(acc_out), 64'(0));
        check("rst overrun", 64'(overrun), 64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // kind: 0 const, 1 cell-3 alternating, 2 ramp, 3 full-scale negative, 4 random
    task automatic run_pulse(input int p, input int kind, input int n, input int md, input bit gaps);
        int xi, xq;
        for (int s = 0; s < n; s++) begin
            if (gaps) idle($urandom_range(0, 2));
            case (kind)
                0: begin xi = 100; xq = -50; end
                1: begin xi = (s == 3) ? ((p % 2 == 0) ? 200 : -200) : 0; xq = 0; end
                2: begin xi = 10 * p; xq = -5 * p; end
                3: begin xi = -2048; xq = -2048; end
                default: begin
                    xi = int'($urandom_range(0, 4095)) - 2048;
                    xq = int'($urandom_range(0, 4095)) - 2048;
                end
            endcase
            drive(s == 0, xi, xq, md);
        end
    endtask

    task automatic run_cpi(input int kind, input int md, input bit gaps);
        for (int p = 0; p < PRF_N; p++) run_pulse(p, kind, RANGE_N, md, gaps);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0; in_valid = 1'b0; pulse_start = 1'b0;
        in_I = '0; in_Q = '0; mode = 2'd0;
        for (int r = 0; r < RANGE_N; r++) begin
            h1i[r] = 0; h1q[r] = 0; h2i[r] = 0; h2q[r] = 0; acc_m[r] = 0;
        end
        model_reset();
        do_reset();

        run_cpi(0, 1, 1'b0);                 // 2-pulse, constant clutter
        idle(6);
        do_reset();
        run_cpi(1, 1, 1'b0);                 // 2-pulse, alternating target in cell 3
        idle(6);
        do_reset();
        run_cpi(2, 2, 1'b0);                 // 3-pulse, linear ramp
        idle(6);
        do_reset();
        run_cpi(3, 0, 1'b0);                 // bypass, full-scale negative
        idle(6);

        do_reset();
        run_pulse(0, 4, 10, 1, 1'b0);        // two samples beyond the last cell
        for (int p = 1; p < PRF_N; p++) run_pulse(p, 4, RANGE_N, (p >= 5) ? 2 : 1, 1'b0);
        run_cpi(4, 2, 1'b1);                 // new mode takes effect at next CPI
        idle(6);

        for (int k = 0; k < 2; k++) begin    // random modes, short pulses, gaps
            int md;
            md = int'($urandom_range(0, 3));
            for (int p = 0; p < PRF_N; p++)
                run_pulse(p, 4, int'($urandom_range(4, RANGE_N)), md, 1'b1);
        end
        idle(6);

        for (int p = 0; p < 7; p++) run_pulse(p, 4, RANGE_N, 2, 1'b0);
        run_pulse(7, 4, 4, 2, 1'b0);
        do_reset();                          // mid pulse 7
        run_cpi(4, 2, 1'b1);
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
